// File: rtl/drop_controller.sv
// Connect-four move engine: accepts column drops, applies gravity into the red/yellow
// occupancy boards, pulses the win checker and latches win/draw game-over.
module drop_controller #(
  parameter int unsigned ROWS         = 6,
  parameter int unsigned COLS         = 7,
  parameter bit          FIRST_YELLOW = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        new_game,
  input  logic        drop,
  input  logic [2:0]  col_sel,
  input  logic        win,
  output logic [41:0] red,
  output logic [41:0] yellow,
  output logic        checkRed,
  output logic        checkYellow,
  output logic        clr_n,
  output logic        turn,
  output logic        busy,
  output logic        invalid,
  output logic        game_over,
  output logic        winner,
  output logic        draw,
  output logic [5:0]  moves
);

  localparam int unsigned CELLS  = 42;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned MOVE_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_PLACE,
    S_CHECK,
    S_WAIT,
    S_OVER
  } state_t;

  state_t              state_q, state_d;
  logic [CELLS-1:0]    red_q, red_d;
  logic [CELLS-1:0]    yellow_q, yellow_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [2:0]          col_q, col_d;
  logic                turn_q, turn_d;
  logic [MOVE_W-1:0]   moves_q, moves_d;
  logic                check_red_q, check_red_d;
  logic                check_yellow_q, check_yellow_d;
  logic                clr_n_q, clr_n_d;
  logic                busy_q, busy_d;
  logic                invalid_q, invalid_d;
  logic                game_over_q, game_over_d;
  logic                winner_q, winner_d;
  logic                draw_q, draw_d;

  logic [CELLS-1:0]    occ_c;
  logic [IDX_W-1:0]    idx_c;
  logic                top_full_c;
  logic                col_bad_c;

  assign occ_c      = red_q | yellow_q;
  assign idx_c      = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
  assign col_bad_c  = (col_sel >= 3'(COLS));
  assign top_full_c = occ_c[IDX_W'(col_sel)];

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      red_q          <= '0;
      yellow_q       <= '0;
      row_q          <= '0;
      col_q          <= '0;
      turn_q         <= FIRST_YELLOW;
      moves_q        <= '0;
      check_red_q    <= 1'b0;
      check_yellow_q <= 1'b0;
      clr_n_q        <= 1'b1;
      busy_q         <= 1'b0;
      invalid_q      <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= 1'b0;
      draw_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      red_q          <= red_d;
      yellow_q       <= yellow_d;
      row_q          <= row_d;
      col_q          <= col_d;
      turn_q         <= turn_d;
      moves_q        <= moves_d;
      check_red_q    <= check_red_d;
      check_yellow_q <= check_yellow_d;
      clr_n_q        <= clr_n_d;
      busy_q         <= busy_d;
      invalid_q      <= invalid_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
      draw_q         <= draw_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    red_d          = red_q;
    yellow_d       = yellow_q;
    row_d          = row_q;
    col_d          = col_q;
    turn_d         = turn_q;
    moves_d        = moves_q;
    check_red_d    = 1'b0;
    check_yellow_d = 1'b0;
    clr_n_d        = 1'b1;
    invalid_d      = 1'b0;
    game_over_d    = game_over_q;
    winner_d       = winner_q;
    draw_d         = draw_q;

    if (new_game) begin
      state_d     = S_IDLE;
      red_d       = '0;
      yellow_d    = '0;
      row_d       = '0;
      col_d       = '0;
      turn_d      = FIRST_YELLOW;
      moves_d     = '0;
      clr_n_d     = 1'b0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
      draw_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (drop) begin
            if (col_bad_c || top_full_c) begin
              invalid_d = 1'b1;
            end else begin
              col_d   = col_sel;
              row_d   = ROW_W'(ROWS - 1);
              state_d = S_SCAN;
            end
          end
        end
        // Walk upward from the bottom; the accept check guarantees row 0 is free.
        S_SCAN: begin
          if (!occ_c[idx_c]) begin
            state_d = S_PLACE;
          end else begin
            row_d = row_q - ROW_W'(1);
          end
        end
        S_PLACE: begin
          if (turn_q) begin
            yellow_d[idx_c] = 1'b1;
          end else begin
            red_d[idx_c] = 1'b1;
          end
          moves_d        = moves_q + MOVE_W'(1);
          check_red_d    = ~turn_q;
          check_yellow_d = turn_q;
          state_d        = S_CHECK;
        end
        S_CHECK: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (win) begin
            state_d     = S_OVER;
            game_over_d = 1'b1;
            winner_d    = turn_q;
          end else if (moves_q == MOVE_W'(CELLS)) begin
            state_d     = S_OVER;
            game_over_d = 1'b1;
            draw_d      = 1'b1;
          end else begin
            turn_d  = ~turn_q;
            state_d = S_IDLE;
          end
        end
        S_OVER: begin
          invalid_d = drop;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_OVER);
  end

  assign red         = red_q;
  assign yellow      = yellow_q;
  assign checkRed    = check_red_q;
  assign checkYellow = check_yellow_q;
  assign clr_n       = clr_n_q;
  assign turn        = turn_q;
  assign busy        = busy_q;
  assign invalid     = invalid_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign draw        = draw_q;
  assign moves       = moves_q;

endmodule

// File: tb/tb_drop_controller.sv
// Scoreboard bench for drop_controller with a behavioural four-in-a-row checker model.
module tb_drop_controller;

  localparam bit FY = 1'b0;
  localparam int ROWS = 6;
  localparam int COLS = 7;

  logic        clk = 1'b0;
  logic        resetn, new_game, drop, win;
  logic [2:0]  col_sel;
  logic [41:0] red, yellow;
  logic        checkRed, checkYellow, clr_n, turn, busy, invalid;
  logic        game_over, winner, draw;
  logic [5:0]  moves;

  drop_controller #(.ROWS(ROWS), .COLS(COLS), .FIRST_YELLOW(FY)) dut (
    .clk(clk), .resetn(resetn), .new_game(new_game), .drop(drop), .col_sel(col_sel),
    .win(win), .red(red), .yellow(yellow), .checkRed(checkRed), .checkYellow(checkYellow),
    .clr_n(clr_n), .turn(turn), .busy(busy), .invalid(invalid), .game_over(game_over),
    .winner(winner), .draw(draw), .moves(moves)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [41:0] red;
    logic [41:0] yellow;
    bit          is_yellow;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  bit          use_checker = 1'b0;
  logic        win_chk;
  logic [41:0] m_red, m_yellow;
  bit          m_turn, m_over, m_winner, m_draw;
  int          m_moves;

  function automatic bit has4(input logic [41:0] b);
    bit f = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int i = r * COLS + c;
        if (c <= 3 && b[i] && b[i+1] && b[i+2] && b[i+3]) f = 1'b1;
        if (r <= 2 && b[i] && b[i+7] && b[i+14] && b[i+21]) f = 1'b1;
        if (r <= 2 && c <= 3 && b[i] && b[i+8] && b[i+16] && b[i+24]) f = 1'b1;
        if (r <= 2 && c >= 3 && b[i] && b[i+6] && b[i+12] && b[i+18]) f = 1'b1;
      end
    end
    return f;
  endfunction

  // Stand-in win checker: registers a sticky win on the check pulse, cleared by clr_n
  always @(posedge clk) begin
    if (!resetn || !clr_n) win_chk <= 1'b0;
    else if ((checkRed && has4(red)) || (checkYellow && has4(yellow))) win_chk <= 1'b1;
  end
  assign win = use_checker & win_chk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_red = '0; m_yellow = '0; m_turn = FY; m_over = 0; m_winner = 0; m_draw = 0; m_moves = 0;
  endtask

  task automatic cmp_state(input string tag);
    checks++; if (red !== m_red) $display("FAIL %s red got %h exp %h", tag, red, m_red); else passes++;
    checks++; if (yellow !== m_yellow) $display("FAIL %s yellow got %h exp %h", tag, yellow, m_yellow); else passes++;
    checks++; if (turn !== m_turn) $display("FAIL %s turn got %b exp %b", tag, turn, m_turn); else passes++;
    checks++; if (moves !== 6'(m_moves)) $display("FAIL %s moves got %0d exp %0d", tag, moves, m_moves); else passes++;
    checks++; if (game_over !== m_over) $display("FAIL %s game_over got %b exp %b", tag, game_over, m_over); else passes++;
    checks++; if (draw !== m_draw) $display("FAIL %s draw got %b exp %b", tag, draw, m_draw); else passes++;
  endtask

  task automatic drop_ok(input int col, input bit poke);
    int   r, idx, n;
    bit   seen;
    exp_t e;
    r = ROWS - 1;
    while (r > 0 && (m_red[r*COLS+col] || m_yellow[r*COLS+col])) r--;
    idx = r * COLS + col;
    if (m_turn) m_yellow[idx] = 1'b1; else m_red[idx] = 1'b1;
    e.red = m_red; e.yellow = m_yellow; e.is_yellow = m_turn; e.lat = 7 - r;
    sb.push_back(e);
    col_sel = 3'(col); drop = 1'b1;
    tick();
    drop = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      if (poke && n == 0) begin drop = 1'b1; col_sel = 3'd4; end
      tick();
      drop = 1'b0;
      n++;
      if (poke && n == 1) begin
        checks++; if (invalid !== 1'b0) $display("FAIL busy_drop invalid got %b exp 0", invalid); else passes++;
      end
      seen = checkRed | checkYellow;
    end
    checks++;
    if (!seen) begin
      $display("FAIL pulse_timeout col %0d got none exp check pulse", col);
      void'(sb.pop_front());
      return;
    end
    passes++;
    e = sb.pop_front();
    checks++; if (red !== e.red) $display("FAIL place_red got %h exp %h", red, e.red); else passes++;
    checks++; if (yellow !== e.yellow) $display("FAIL place_yellow got %h exp %h", yellow, e.yellow); else passes++;
    checks++; if (checkYellow !== e.is_yellow) $display("FAIL pulse_color got %b exp %b", checkYellow, e.is_yellow); else passes++;
    checks++; if (n !== e.lat) $display("FAIL latency got %0d exp %0d", n, e.lat); else passes++;
    tick();
    checks++; if ({checkRed, checkYellow} !== 2'b00) $display("FAIL pulse_width got %b exp 00", {checkRed, checkYellow}); else passes++;
    tick();
    m_moves++;
    if (use_checker && has4(m_turn ? m_yellow : m_red)) begin m_over = 1; m_winner = m_turn; end
    else if (m_moves == 42) begin m_over = 1; m_draw = 1; end
    else m_turn = ~m_turn;
    cmp_state("after_move");
    checks++; if (busy !== 1'b0) $display("FAIL busy_end got %b exp 0", busy); else passes++;
    if (m_over && !m_draw) begin
      checks++; if (winner !== m_winner) $display("FAIL winner got %b exp %b", winner, m_winner); else passes++;
    end
  endtask

  task automatic drop_reject(input int col);
    col_sel = 3'(col); drop = 1'b1;
    tick();
    drop = 1'b0;
    checks++; if (invalid !== 1'b1) $display("FAIL reject_pulse col %0d got %b exp 1", col, invalid); else passes++;
    tick();
    checks++; if (invalid !== 1'b0) $display("FAIL reject_width got %b exp 0", invalid); else passes++;
    cmp_state("after_reject");
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear();
    checks++; if (clr_n !== 1'b0) $display("FAIL clr_n_low got %b exp 0", clr_n); else passes++;
    cmp_state("new_game");
    tick();
    checks++; if (clr_n !== 1'b1) $display("FAIL clr_n_release got %b exp 1", clr_n); else passes++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; new_game = 1'b0; drop = 1'b0; col_sel = '0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    model_clear();
    cmp_state("reset");
    checks++; if ({busy, invalid, checkRed, checkYellow, winner} !== 5'b0) $display("FAIL reset_flags got %b exp 00000", {busy, invalid, checkRed, checkYellow, winner}); else passes++;
    checks++; if (clr_n !== 1'b1) $display("FAIL reset_clr_n got %b exp 1", clr_n); else passes++;
  endtask

  task automatic test_first_moves();
    drop_ok(3, 1'b0);
    drop_ok(3, 1'b0);
  endtask

  task automatic test_busy_ignored();
    drop_ok(2, 1'b1);
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL busy_no_queue got %b exp 0", busy); else passes++;
    cmp_state("busy_no_queue");
  endtask

  task automatic test_column_full();
    do_new_game();
    for (int k = 0; k < ROWS; k++) drop_ok(0, 1'b0);
    drop_reject(0);
    drop_reject(7);
  endtask

  task automatic test_win();
    do_new_game();
    use_checker = 1'b1;
    for (int k = 0; k < 3; k++) begin drop_ok(0, 1'b0); drop_ok(1, 1'b0); end
    drop_ok(0, 1'b0);
    drop_reject(2);
    do_new_game();
    use_checker = 1'b0;
  endtask

  task automatic test_draw();
    for (int c = 0; c < COLS; c++)
      for (int k = 0; k < ROWS; k++) drop_ok(c, 1'b0);
    drop_reject(3);
    do_new_game();
  endtask

  task automatic test_reset_mid_scan();
    drop_ok(2, 1'b0);
    drop_ok(2, 1'b0);
    col_sel = 3'd2; drop = 1'b1;
    tick();
    drop = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL mid_scan_busy got %b exp 1", busy); else passes++;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    model_clear();
    cmp_state("reset_mid_scan");
    tick(); tick(); tick();
    cmp_state("reset_mid_scan_settled");
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
  endtask

  initial begin
    test_reset();
    test_first_moves();
    test_busy_ignored();
    test_column_full();
    test_win();
    test_draw();
    test_reset_mid_scan();
    checks++; if (sb.size() !== 0) $display("FAIL scoreboard_left got %0d exp 0", sb.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
